// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch unit: InstructionBuffer fetch handshake, Decoder
// issue port and the branch/jump redirect.
interface fetch_unit_if;
  logic        ib_request_out;
  logic [31:0] ib_address_out;
  logic        ib_ready_in;
  logic [31:0] ib_instruction_in;
  logic        dec_ready_in;
  logic        dec_issue_signal_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;

  modport master (
    output ib_request_out,
    output ib_address_out,
    input  ib_ready_in,
    input  ib_instruction_in,
    input  dec_ready_in,
    output dec_issue_signal_out,
    output dec_inst_out,
    output dec_pc_out,
    input  redirect_valid_in,
    input  redirect_pc_in
  );

  modport slave (
    input  ib_request_out,
    input  ib_address_out,
    output ib_ready_in,
    output ib_instruction_in,
    output dec_ready_in,
    input  dec_issue_signal_out,
    input  dec_inst_out,
    input  dec_pc_out,
    output redirect_valid_in,
    output redirect_pc_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a circular
// {inst, pc} queue that issues in order to the Decoder; redirects flush everything.
module fetch_unit #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAITING,
    DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  state_t           state;
  state_t           state_next;
  entry_t           queue [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full;

  logic [31:0]      pc;
  logic [31:0]      req_addr;
  logic             issue;
  logic [31:0]      issue_inst;
  logic [31:0]      issue_pc;

  logic             flush;
  logic             do_request;
  logic             do_push;
  logic             do_pop;

  // A slot is reserved at request time: only one fetch is ever in flight, and
  // it is launched from IDLE only while the queue has room.
  assign full = (count == CNT_W'(QUEUE_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    flush      = bus.redirect_valid_in;
    do_request = 1'b0;
    do_push    = 1'b0;
    do_pop     = !flush && (count != '0) && bus.dec_ready_in;
    unique case (state)
      IDLE: begin
        if (!flush && !full) begin
          do_request = 1'b1;
          state_next = WAITING;
        end
      end
      WAITING: begin
        if (bus.ib_ready_in) begin
          do_push    = !flush;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        // The stale response retires the outstanding fetch even when another
        // redirect lands on the same edge; waiting longer would never end.
        if (bus.ib_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_addr   <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      issue      <= 1'b0;
      issue_inst <= '0;
      issue_pc   <= '0;
    end else begin
      if (flush)           pc <= bus.redirect_pc_in & ~32'd3;
      else if (do_request) pc <= pc + 32'd4;

      if (do_request) req_addr <= pc;

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + PTR_W'(1);
        if (do_pop)  head <= head + PTR_W'(1);
        unique case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      issue <= do_pop;
      if (do_pop) begin
        issue_inst <= queue[head].inst;
        issue_pc   <= queue[head].pc;
      end else begin
        issue_inst <= '0;
      end
    end
  end

  // NOTE: the queue storage has no reset; occupancy is tracked by count and
  // the pointers, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) queue[tail] <= {bus.ib_instruction_in, req_addr};
  end

  assign bus.ib_request_out       = (state == WAITING);
  assign bus.ib_address_out       = req_addr;
  assign bus.dec_issue_signal_out = issue;
  assign bus.dec_inst_out         = issue_inst;
  assign bus.dec_pc_out           = issue_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// redirect/reset sequences and a randomized run against a queue-based model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.ib_ready_in       = 1'b0;
    bus.ib_instruction_in = 32'h0;
    bus.dec_ready_in      = 1'b0;
    bus.redirect_valid_in = 1'b0;
    bus.redirect_pc_in    = 32'h0;
  endtask

  // Reset is released mid-cycle; the next step() is the first edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    quiet_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // InstructionBuffer that answers every request on the following edge.
  task automatic resp_cycle();
    bus.ib_ready_in       = bus.ib_request_out;
    bus.ib_instruction_in = 32'hA000_0000 | bus.ib_address_out;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ready;
    logic [31:0] inst;
    logic        dec_ready;
    logic        req;
    logic [31:0] addr;
    logic        issue;
    logic [31:0] dinst;
    logic [31:0] dpc;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic [31:0] inst, logic drdy, logic req,
                              logic [31:0] addr, logic iss, logic [31:0] di, logic [31:0] dp);
    vec_t v;
    v.ready = rdy; v.inst = inst; v.dec_ready = drdy;
    v.req = req; v.addr = addr; v.issue = iss; v.dinst = di; v.dpc = dp;
    return v;
  endfunction

  vec_t vt [8];

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] m_pc, m_addr, m_inst, m_dpc;
  logic        m_busy, m_drop, m_issue;

  function automatic void model_reset();
    mq.delete();
    m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_dpc = 32'h0;
    m_busy = 1'b0; m_drop = 1'b0; m_issue = 1'b0;
  endfunction

  // One clock edge: m_busy = a fetch is outstanding, m_drop = its data is void.
  function automatic void model_edge(logic rdy, logic [31:0] inst, logic drdy,
                                     logic redir, logic [31:0] rpc);
    ent_t hd;
    logic pop;
    if (redir) begin
      mq.delete();
      m_pc    = rpc & ~32'd3;
      m_issue = 1'b0;
      m_inst  = 32'h0;
      if (m_busy) begin
        if (rdy) begin m_busy = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else begin
      pop = (mq.size() > 0) && drdy;
      hd  = '{32'h0, 32'h0};
      if (pop) hd = mq[0];
      if (m_busy) begin
        if (rdy) begin
          if (!m_drop) mq.push_back('{inst, m_addr});
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end else if (mq.size() < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_pc;
        m_pc   = m_pc + 32'd4;
      end
      if (pop) begin
        void'(mq.pop_front());
        m_issue = 1'b1;
        m_inst  = hd.inst;
        m_dpc   = hd.pc;
      end else begin
        m_issue = 1'b0;
        m_inst  = 32'h0;
      end
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addrs [$];
    logic [31:0] iss_inst [$];
    logic [31:0] iss_pc [$];
    logic [31:0] first_req;
    logic        got_req;
    logic        seen_bad;
    logic        r_rdy, r_drdy, r_redir;
    logic [31:0] r_inst, r_rpc;

    vt[0] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0);
    vt[1] = mk(1'b1, 32'h11110000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0);
    vt[2] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h4, 1'b1, 32'h11110000, 32'h0);
    vt[3] = mk(1'b1, 32'h22220004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0);
    vt[4] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h8, 1'b1, 32'h22220004, 32'h4);
    vt[5] = mk(1'b1, 32'h33330008, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h4);
    vt[6] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hC, 1'b1, 32'h33330008, 32'h8);
    vt[7] = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hC, 1'b0, 32'h0,        32'h8);

    // Reset state, then the basic fetch/issue stream from the table.
    do_reset();
    rst = 1'b1;
    #1;
    check1 ("rst_req",   bus.ib_request_out, 1'b0);
    check32("rst_addr",  bus.ib_address_out, 32'h0);
    check1 ("rst_issue", bus.dec_issue_signal_out, 1'b0);
    check32("rst_inst",  bus.dec_inst_out, 32'h0);
    check32("rst_pc",    bus.dec_pc_out, 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.ib_ready_in       = vt[i].ready;
      bus.ib_instruction_in = vt[i].inst;
      bus.dec_ready_in      = vt[i].dec_ready;
      step();
      check1("tbl_req", bus.ib_request_out, vt[i].req);
      if (vt[i].req) check32("tbl_addr", bus.ib_address_out, vt[i].addr);
      check1 ("tbl_issue", bus.dec_issue_signal_out, vt[i].issue);
      check32("tbl_dinst", bus.dec_inst_out, vt[i].dinst);
      check32("tbl_dpc",   bus.dec_pc_out, vt[i].dpc);
    end

    // Full queue stalls fetching; draining issues in order and resumes at 0x10.
    do_reset();
    addrs.delete();
    for (int i = 0; i < 20; i++) begin
      if (bus.ib_request_out) addrs.push_back(bus.ib_address_out);
      resp_cycle();
    end
    check32("fill_count", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++)
      check32("fill_addr", addrs[i], 32'(4 * i));
    check1("fill_stall", bus.ib_request_out, 1'b0);
    bus.dec_ready_in = 1'b1;
    iss_inst.delete(); iss_pc.delete();
    got_req = 1'b0; first_req = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      if (bus.ib_request_out && !got_req) begin
        got_req   = 1'b1;
        first_req = bus.ib_address_out;
      end
      resp_cycle();
      if (bus.dec_issue_signal_out) begin
        iss_inst.push_back(bus.dec_inst_out);
        iss_pc.push_back(bus.dec_pc_out);
      end
    end
    check1("drain_enough", iss_pc.size() >= 4, 1'b1);
    for (int i = 0; i < iss_pc.size() && i < 4; i++) begin
      check32("drain_pc",   iss_pc[i],   32'(4 * i));
      check32("drain_inst", iss_inst[i], 32'hA000_0000 | 32'(4 * i));
    end
    check32("resume_addr", first_req, 32'h10);

    // Redirect while WAITING: late data is discarded, refetch at aligned target.
    do_reset();
    bus.dec_ready_in = 1'b1;
    step();
    check1("rd_wait_req", bus.ib_request_out, 1'b1);
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 32'h1003;
    step();
    check1("rd_discard_req", bus.ib_request_out, 1'b0);
    bus.redirect_valid_in = 1'b0;
    step();
    check1("rd_discard_req2", bus.ib_request_out, 1'b0);
    step();
    bus.ib_ready_in       = 1'b1;
    bus.ib_instruction_in = 32'hDEADBEEF;
    step();
    check1("rd_drop_req", bus.ib_request_out, 1'b0);
    bus.ib_ready_in = 1'b0;
    step();
    check1 ("rd_new_req",  bus.ib_request_out, 1'b1);
    check32("rd_new_addr", bus.ib_address_out, 32'h1000);
    check1 ("rd_no_issue", bus.dec_issue_signal_out, 1'b0);
    seen_bad = 1'b0;
    iss_pc.delete();
    for (int i = 0; i < 10; i++) begin
      resp_cycle();
      if (bus.dec_issue_signal_out) begin
        if (bus.dec_inst_out == 32'hDEADBEEF) seen_bad = 1'b1;
        iss_pc.push_back(bus.dec_pc_out);
      end
    end
    check1("rd_no_deadbeef", seen_bad, 1'b0);
    check1("rd_issued", iss_pc.size() > 0, 1'b1);
    if (iss_pc.size() > 0) check32("rd_first_pc", iss_pc[0], 32'h1000);

    // Redirect coincident with ib data and a pending issue.
    do_reset();
    step();
    bus.ib_ready_in       = 1'b1;
    bus.ib_instruction_in = 32'h12340000;
    step();
    bus.ib_ready_in = 1'b0;
    step();
    check1 ("co_req",  bus.ib_request_out, 1'b1);
    check32("co_addr", bus.ib_address_out, 32'h4);
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 32'h2000;
    bus.ib_ready_in       = 1'b1;
    bus.ib_instruction_in = 32'h55555555;
    bus.dec_ready_in      = 1'b1;
    step();
    check1 ("co_issue", bus.dec_issue_signal_out, 1'b0);
    check32("co_inst",  bus.dec_inst_out, 32'h0);
    check1 ("co_req0",  bus.ib_request_out, 1'b0);
    bus.redirect_valid_in = 1'b0;
    bus.ib_ready_in       = 1'b0;
    step();
    check1 ("co_new_req",  bus.ib_request_out, 1'b1);
    check32("co_new_addr", bus.ib_address_out, 32'h2000);
    check1 ("co_empty",    bus.dec_issue_signal_out, 1'b0);

    // pc wraps modulo 2^32.
    do_reset();
    bus.dec_ready_in      = 1'b1;
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 32'hFFFF_FFFC;
    step();
    check1("wr_idle", bus.ib_request_out, 1'b0);
    bus.redirect_valid_in = 1'b0;
    step();
    check32("wr_addr_hi", bus.ib_address_out, 32'hFFFF_FFFC);
    bus.ib_ready_in       = 1'b1;
    bus.ib_instruction_in = 32'h77;
    step();
    bus.ib_ready_in = 1'b0;
    step();
    check1 ("wr_req",   bus.ib_request_out, 1'b1);
    check32("wr_addr0", bus.ib_address_out, 32'h0);
    check32("wr_dpc",   bus.dec_pc_out, 32'hFFFF_FFFC);

    // Asynchronous reset mid-fetch, stale ib_ready_in across the release.
    do_reset();
    bus.dec_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) resp_cycle();
    check1 ("ar_pre_req", bus.ib_request_out, 1'b1);
    check32("ar_pre_pc",  bus.dec_pc_out, 32'h4);
    bus.ib_ready_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check1 ("ar_req",   bus.ib_request_out, 1'b0);
    check32("ar_addr",  bus.ib_address_out, 32'h0);
    check1 ("ar_issue", bus.dec_issue_signal_out, 1'b0);
    check32("ar_inst",  bus.dec_inst_out, 32'h0);
    check32("ar_pc",    bus.dec_pc_out, 32'h0);
    #2;
    rst = 1'b0;
    step();
    check1 ("ar_first_req",  bus.ib_request_out, 1'b1);
    check32("ar_first_addr", bus.ib_address_out, 32'h0);
    check1 ("ar_no_issue",   bus.dec_issue_signal_out, 1'b0);
    bus.ib_ready_in = 1'b0;
    step();
    check1("ar_still_wait", bus.ib_request_out, 1'b1);
    check1("ar_no_issue2",  bus.dec_issue_signal_out, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      r_rdy   = ($urandom % 3) == 0;
      r_inst  = $urandom;
      r_drdy  = ($urandom % 3) != 0;
      r_redir = ($urandom % 20) == 0;
      r_rpc   = $urandom;
      bus.ib_ready_in       = r_rdy;
      bus.ib_instruction_in = r_inst;
      bus.dec_ready_in      = r_drdy;
      bus.redirect_valid_in = r_redir;
      bus.redirect_pc_in    = r_rpc;
      model_edge(r_rdy, r_inst, r_drdy, r_redir, r_rpc);
      step();
      check1("rnd_req", bus.ib_request_out, m_busy && !m_drop);
      if (m_busy && !m_drop) check32("rnd_addr", bus.ib_address_out, m_addr);
      check1 ("rnd_issue", bus.dec_issue_signal_out, m_issue);
      check32("rnd_inst",  bus.dec_inst_out, m_inst);
      check32("rnd_dpc",   bus.dec_pc_out, m_dpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, number of fetched-instruction entries buffered ahead of the Decoder; power of two, ≥2.
REQ-002 Parameter RESET_PC, default 32'h0, pc value loaded on reset.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ib_request_out  output  1  a fetch request to InstructionBuffer is pending.
REQ-006 ib_address_out  output  32  byte address of the pending fetch.
REQ-007 ib_ready_in  input  1  InstructionBuffer returns data this cycle.
REQ-008 ib_instruction_in  input  32  instruction word, valid with ib_ready_in.
REQ-009 dec_ready_in  input  1  Decoder can accept an instruction this cycle.
REQ-010 dec_issue_signal_out  output  1  one-cycle pulse: dec_inst_out/dec_pc_out valid.
REQ-011 dec_inst_out  output  32  issued instruction word.
REQ-012 dec_pc_out  output  32  address of the issued instruction.
REQ-013 redirect_valid_in  input  1  branch/jump redirect; flush and refetch.
REQ-014 redirect_pc_in  input  32  new fetch address, valid with redirect_valid_in.

Function
REQ-015 Fetch FSM SHALL have states IDLE, WAITING, DISCARD; the queue SHALL be a circular buffer of {inst, pc} pairs with head/tail pointers wrapping modulo QUEUE_DEPTH and a count 0..QUEUE_DEPTH.
REQ-016 IDLE, no redirect, count < QUEUE_DEPTH: SHALL drive ib_request_out=1, ib_address_out=pc, set pc<=pc+4 (modulo 2^32), go WAITING; count == QUEUE_DEPTH: stay IDLE, ib_request_out=0.
REQ-017 WAITING: ib_request_out and ib_address_out SHALL hold until ib_ready_in; on ib_ready_in, push {ib_instruction_in, ib_address_out}, go IDLE.
REQ-018 At most one fetch SHALL be in flight; queue push SHALL never overflow (slot reserved at request time).
REQ-019 Issue: when count>0 and dec_ready_in, the next edge SHALL register head entry onto dec_inst_out/dec_pc_out, pulse dec_issue_signal_out for exactly one cycle, pop head; otherwise dec_issue_signal_out=0, dec_inst_out=0, dec_pc_out holds.
REQ-020 Push and pop in the same cycle SHALL both occur, count unchanged; push into an empty queue SHALL be issuable no earlier than the following edge (ib_ready_in at edge N -> dec_issue_signal_out high after edge N+1).
REQ-021 redirect_valid_in SHALL take priority over all other events: queue flushed (count=0, head=tail), pc<=redirect_pc_in with bits[1:0] forced 0, dec_issue_signal_out=0 that cycle, no push of any same-cycle ib data.
REQ-022 Redirect in IDLE -> IDLE; in WAITING without ib_ready_in -> DISCARD (ib_request_out=0); in WAITING with ib_ready_in -> IDLE, data dropped; in DISCARD -> DISCARD with pc updated.
REQ-023 DISCARD: ib_request_out=0; on ib_ready_in the data SHALL be dropped and FSM -> IDLE; new fetch starts from the latest redirected pc.
REQ-024 dec_ready_in low SHALL never drop or reorder queued entries; issue order SHALL equal fetch order.

Reset
REQ-025 While rst high, independent of clk: state IDLE, pc=RESET_PC, queue empty, ib_request_out=0, ib_address_out=0, dec_issue_signal_out=0, dec_inst_out=0, dec_pc_out=0.
REQ-026 Reset asserted mid-fetch SHALL abandon the in-flight request without DISCARD; first request after release SHALL be to RESET_PC on the first rising edge with rst low.

Verification
REQ-027 Reset release, ib_ready_in one cycle after each request, dec_ready_in=1 -> requests at 0x0,0x4,0x8; issues with dec_pc_out 0x0,0x4,0x8 in order, inst words match.
REQ-028 QUEUE_DEPTH=4, dec_ready_in=0, instant ib responses -> exactly 4 requests (0x0..0xC), ib_request_out then stays 0; raising dec_ready_in drains 4 issues in order, fetching resumes at 0x10.
REQ-029 Redirect to 0x1003 while WAITING, ib_ready_in 3 cycles later with 0xDEADBEEF -> DEADBEEF never issued, queue empty, next request at 0x1000.
REQ-030 Redirect coincident with ib_ready_in and a pending issue -> no issue pulse that cycle, data dropped, next request at redirect address.
REQ-031 pc=0xFFFFFFFC fetch -> next request address 0x00000000.
REQ-032 rst pulse between clock edges while WAITING -> outputs zero immediately; after release first request at RESET_PC, stale ib_ready_in ignored until new request.
